// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register: captures decoded controls and operands,
// supports hazard flush (bubble) and stall (hold), and counts injected bubbles.
module id_ex_stage_reg #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FlushE,
    input  logic            StallE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic [CNTW-1:0] BubbleCnt
);

    logic            valid_q,     valid_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_write_q, mem_write_d;
    logic            jump_q,      jump_d;
    logic            branch_q,    branch_d;
    logic            alu_src_q,   alu_src_d;
    logic [1:0]      result_src_q, result_src_d;
    logic [2:0]      alu_ctrl_q,  alu_ctrl_d;
    logic [XLEN-1:0] rd1_q,       rd1_d;
    logic [XLEN-1:0] rd2_q,       rd2_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] pc_plus4_q,  pc_plus4_d;
    logic [XLEN-1:0] imm_ext_q,   imm_ext_d;
    logic [REGW-1:0] rs1_q,       rs1_d;
    logic [REGW-1:0] rs2_q,       rs2_d;
    logic [REGW-1:0] rd_q,        rd_d;
    logic [CNTW-1:0] bubble_q,    bubble_d;

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        jump_d       = jump_q;
        branch_d     = branch_q;
        alu_src_d    = alu_src_q;
        result_src_d = result_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        imm_ext_d    = imm_ext_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        bubble_d     = bubble_q;

        if (FlushE) begin
            // Bubble clears indices too so a flushed slot never forwards.
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            jump_d       = 1'b0;
            branch_d     = 1'b0;
            alu_src_d    = 1'b0;
            result_src_d = '0;
            alu_ctrl_d   = '0;
            rd1_d        = '0;
            rd2_d        = '0;
            pc_d         = '0;
            pc_plus4_d   = '0;
            imm_ext_d    = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            if (bubble_q != '1)
                bubble_d = bubble_q + 1'b1;
        end else if (!StallE) begin
            valid_d      = ValidD;
            reg_write_d  = RegWriteD & ValidD;
            mem_write_d  = MemWriteD & ValidD;
            jump_d       = JumpD & ValidD;
            branch_d     = BranchD & ValidD;
            alu_src_d    = ALUSrcD;
            result_src_d = ResultSrcD;
            alu_ctrl_d   = ALUControlD;
            rd1_d        = RD1D;
            rd2_d        = RD2D;
            pc_d         = PCD;
            pc_plus4_d   = PCPlus4D;
            imm_ext_d    = ImmExtD;
            rs1_d        = Rs1D;
            rs2_d        = Rs2D;
            rd_d         = RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            result_src_q <= '0;
            alu_ctrl_q   <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            pc_q         <= '0;
            pc_plus4_q   <= '0;
            imm_ext_q    <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            bubble_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            branch_q     <= branch_d;
            alu_src_q    <= alu_src_d;
            result_src_q <= result_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            imm_ext_q    <= imm_ext_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            bubble_q     <= bubble_d;
        end
    end

    assign ValidE      = valid_q;
    assign RegWriteE   = reg_write_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUSrcE     = alu_src_q;
    assign ResultSrcE  = result_src_q;
    assign ALUControlE = alu_ctrl_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;
    assign ImmExtE     = imm_ext_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign BubbleCnt   = bubble_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized self-checking bench for id_ex_stage_reg against a behavioural
// model of the stage contents; bubble counter narrowed to 4 bits.
module tb_id_ex_stage_reg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 4;
    localparam int unsigned CMAX = (1 << CNTW) - 1;

    typedef struct packed {
        logic        v, rw, mw, j, b, as;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
    } stage_t;

    logic clk = 1'b0;
    logic reset, FlushE, StallE;
    stage_t din, obs, exp_s;
    int unsigned exp_cnt;
    int unsigned total = 0;
    int unsigned bad = 0;

    logic [CNTW-1:0] BubbleCnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE), .StallE(StallE),
        .ValidD(din.v), .RegWriteD(din.rw), .MemWriteD(din.mw),
        .JumpD(din.j), .BranchD(din.b), .ALUSrcD(din.as),
        .ResultSrcD(din.rs), .ALUControlD(din.alu),
        .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .PCPlus4D(din.pc4),
        .ImmExtD(din.imm), .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .ValidE(obs.v), .RegWriteE(obs.rw), .MemWriteE(obs.mw),
        .JumpE(obs.j), .BranchE(obs.b), .ALUSrcE(obs.as),
        .ResultSrcE(obs.rs), .ALUControlE(obs.alu),
        .RD1E(obs.rd1), .RD2E(obs.rd2), .PCE(obs.pc), .PCPlus4E(obs.pc4),
        .ImmExtE(obs.imm), .Rs1E(obs.rs1), .Rs2E(obs.rs2), .RdE(obs.rd),
        .BubbleCnt(BubbleCnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic rand_inputs();
        din.v   = ($urandom_range(0, 9) < 7);
        din.rw  = $urandom_range(0, 1);
        din.mw  = $urandom_range(0, 1);
        din.j   = $urandom_range(0, 1);
        din.b   = $urandom_range(0, 1);
        din.as  = $urandom_range(0, 1);
        din.rs  = 2'($urandom_range(0, 3));
        din.alu = 3'($urandom_range(0, 7));
        din.rd1 = $urandom;
        din.rd2 = $urandom;
        din.pc  = $urandom;
        din.pc4 = din.pc + 32'd4;
        din.imm = $urandom;
        din.rs1 = 5'($urandom_range(0, 31));
        din.rs2 = 5'($urandom_range(0, 31));
        din.rd  = 5'($urandom_range(1, 31));
    endtask

    // One rising edge: advance the model with the values present at the edge,
    // then compare every output shortly after.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            exp_s   = '0;
            exp_cnt = 0;
        end else if (FlushE) begin
            exp_s   = '0;
            exp_cnt = (exp_cnt >= CMAX) ? CMAX : exp_cnt + 1;
        end else if (!StallE) begin
            exp_s = din;
            if (!din.v) begin
                exp_s.rw = 1'b0;
                exp_s.mw = 1'b0;
                exp_s.j  = 1'b0;
                exp_s.b  = 1'b0;
            end
        end
        #1;
        check("ctrl", 32'({obs.v, obs.rw, obs.mw, obs.j, obs.b, obs.as, obs.rs, obs.alu}),
                      32'({exp_s.v, exp_s.rw, exp_s.mw, exp_s.j, exp_s.b, exp_s.as, exp_s.rs, exp_s.alu}));
        check("rd1", obs.rd1, exp_s.rd1);
        check("rd2", obs.rd2, exp_s.rd2);
        check("pc", obs.pc, exp_s.pc);
        check("pc4", obs.pc4, exp_s.pc4);
        check("imm", obs.imm, exp_s.imm);
        check("idx", 32'({obs.rs1, obs.rs2, obs.rd}), 32'({exp_s.rs1, exp_s.rs2, exp_s.rd}));
        check("bubble", 32'(BubbleCnt), exp_cnt);
    endtask

    initial begin
        exp_s   = '0;
        exp_cnt = 0;
        FlushE  = 1'b1;
        StallE  = 1'b1;
        reset   = 1'b0;
        din     = '1;

        // Reset overrides flush/stall with all inputs nonzero
        step();
        step();
        check("reset_valid", 32'(obs.v), 32'd0);
        check("reset_cnt", 32'(BubbleCnt), 32'd0);

        reset  = 1'b1;
        FlushE = 1'b0;
        StallE = 1'b0;
        din = '0;
        din.v = 1'b1; din.rw = 1'b1; din.rs = 2'b01;
        din.rd1 = 32'h1234_5678; din.rd = 5'd7;
        step();
        check("pass_rd1", obs.rd1, 32'h1234_5678);
        check("pass_rd", 32'(obs.rd), 32'd7);
        check("pass_rs", 32'(obs.rs), 32'd1);

        din.rd = 5'd3;
        step();
        StallE = 1'b1;
        din.rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            din.rd2 = $urandom;
            step();
            check("stall_rd", 32'(obs.rd), 32'd3);
        end
        StallE = 1'b0;
        step();
        check("unstall_rd", 32'(obs.rd), 32'd9);

        FlushE = 1'b1; StallE = 1'b1; din.mw = 1'b1;
        step();
        check("flush_mw", 32'(obs.mw), 32'd0);
        check("flush_cnt", 32'(BubbleCnt), 32'd1);

        FlushE = 1'b0; StallE = 1'b0;
        din.v = 1'b0; din.rw = 1'b1; din.mw = 1'b1; din.pc = 32'hCAFE_0000;
        step();
        check("inv_rw", 32'({obs.v, obs.rw, obs.mw}), 32'd0);
        check("inv_pc", obs.pc, 32'hCAFE_0000);

        FlushE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            step();
        end
        check("sat_cnt", 32'(BubbleCnt), 32'd15);
        FlushE = 1'b0;
        reset  = 1'b0;
        step();
        check("sat_reset", 32'(BubbleCnt), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            reset  = ($urandom_range(0, 99) >= 3);
            FlushE = ($urandom_range(0, 99) < 15);
            StallE = ($urandom_range(0, 99) < 25);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
